// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter
//   Age-ordered issue scheduler between the reservation-station slot storage
//   and the ALU issue port. It records the order in which RS slots are
//   allocated (an age matrix) and every cycle picks the oldest slot whose
//   operands are ready. The pick is held in a valid/ready output register
//   until the ALU accepts it. A ROB flush drops all tracked slots.
//
//   Optional feature: define ARB_PERF_CNT_EN to add the stall and issue
//   performance counters (arb_stall_cnt_out, arb_issue_cnt_out).
//
// Ports
//   clk_in               clock, all state updates on posedge
//   rst_in               synchronous reset, active-low (wins over everything)
//   rdy_in               global enable; 0 freezes all state
//   rob_arb_rst_in       misprediction flush, active-high
//   rs_arb_alloc_en_in   dispatcher writes a slot this cycle
//   rs_arb_alloc_idx_in  index of the slot being written
//   rs_arb_ready_in      per-slot operands-ready vector (bit 0 ignored)
//   alu_arb_rdy_in       ALU accepts an instruction this cycle
//   arb_alu_valid_out    issue request valid
//   arb_alu_idx_out      slot index being issued
//   arb_occupancy_out    tracked slots not yet selected
//   arb_err_out          sticky flag: an illegal allocation was seen
//   arb_stall_cnt_out    (ARB_PERF_CNT_EN) edges with valid_out=1, rdy=0
//   arb_issue_cnt_out    (ARB_PERF_CNT_EN) completed transfers
module rs_issue_arbiter #(
    parameter int RS_COUNT = 16,
    parameter int IDX_W    = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                rob_arb_rst_in,
    input  logic                rs_arb_alloc_en_in,
    input  logic [IDX_W-1:0]    rs_arb_alloc_idx_in,
    input  logic [RS_COUNT-1:0] rs_arb_ready_in,
    input  logic                alu_arb_rdy_in,
    output logic                arb_alu_valid_out,
    output logic [IDX_W-1:0]    arb_alu_idx_out,
    output logic [IDX_W:0]      arb_occupancy_out,
    output logic                arb_err_out
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         arb_stall_cnt_out,
    output logic [31:0]         arb_issue_cnt_out
`endif
);

    logic [RS_COUNT-1:0] r_valid;
    // r_older[i][j] = 1 : slot i was allocated before slot j
    logic [RS_COUNT-1:0] r_older [RS_COUNT];
    logic                r_vout;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W:0]      r_occ;
    logic                r_err;

    logic [RS_COUNT-1:0] w_cand;
    logic [RS_COUNT-1:0] w_blk;
    logic [RS_COUNT-1:0] w_win;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_has_win;
    logic                w_load;
    logic                w_grant;
    logic                w_alloc_ok;
    logic                w_alloc_bad;
    logic [RS_COUNT-1:0] w_valid_nxt;

    // A candidate is blocked if any other candidate is older than it. The
    // age matrix is a strict total order over valid slots, so at most one
    // candidate survives and w_win is one-hot (or zero).
    always_comb begin
        w_cand    = r_valid & rs_arb_ready_in;
        w_cand[0] = 1'b0;
        w_blk     = '0;
        w_win     = '0;
        w_win_idx = '0;
        for (int i = 1; i < RS_COUNT; i++) begin
            for (int j = 1; j < RS_COUNT; j++) begin
                w_blk[i] = w_blk[i] | (w_cand[j] & r_older[j][i]);
            end
            w_win[i] = w_cand[i] & ~w_blk[i];
            if (w_win[i]) begin
                w_win_idx = w_win_idx | IDX_W'(i);
            end
        end
    end

    assign w_has_win   = |w_win;
    assign w_load      = ~r_vout | alu_arb_rdy_in;
    assign w_grant     = w_load & w_has_win;
    assign w_alloc_ok  = rs_arb_alloc_en_in && (rs_arb_alloc_idx_in != '0)
                         && !r_valid[rs_arb_alloc_idx_in];
    assign w_alloc_bad = rs_arb_alloc_en_in && !w_alloc_ok;

    // Selection is made on pre-edge state, so a slot allocated this cycle
    // cannot also be granted this cycle.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_grant) begin
            w_valid_nxt = w_valid_nxt & ~w_win;
        end
        if (w_alloc_ok) begin
            w_valid_nxt[rs_arb_alloc_idx_in] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_valid <= '0;
            for (int i = 0; i < RS_COUNT; i++) begin
                r_older[i] <= '0;
            end
            r_vout <= 1'b0;
            r_idx  <= '0;
            r_occ  <= '0;
            r_err  <= 1'b0;
        end else if (rdy_in) begin
            if (rob_arb_rst_in) begin
                r_valid <= '0;
                r_occ   <= '0;
                r_vout  <= 1'b0;
            end else begin
                r_valid <= w_valid_nxt;
                if (w_load) begin
                    r_vout <= w_has_win;
                    if (w_has_win) begin
                        r_idx <= w_win_idx;
                    end
                end
                // New slot is younger than everything currently tracked.
                // Stale bits left in rows of freed slots are harmless: a row
                // is cleared when its slot is allocated again.
                if (w_alloc_ok) begin
                    r_older[rs_arb_alloc_idx_in] <= '0;
                    for (int j = 1; j < RS_COUNT; j++) begin
                        if (r_valid[j]) begin
                            r_older[j][rs_arb_alloc_idx_in] <= 1'b1;
                        end
                    end
                end
                if (w_alloc_ok && !w_grant) begin
                    r_occ <= r_occ + (IDX_W+1)'(1);
                end else if (!w_alloc_ok && w_grant) begin
                    r_occ <= r_occ - (IDX_W+1)'(1);
                end
                if (w_alloc_bad) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign arb_alu_valid_out = r_vout;
    assign arb_alu_idx_out   = r_idx;
    assign arb_occupancy_out = r_occ;
    assign arb_err_out       = r_err;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_issue_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else if (rdy_in && !rob_arb_rst_in) begin
            if (r_vout && !alu_arb_rdy_in) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (r_vout && alu_arb_rdy_in) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
        end
    end

    assign arb_stall_cnt_out = r_stall_cnt;
    assign arb_issue_cnt_out = r_issue_cnt;
`endif

endmodule
